step_sequencer: RTL and testbench
=================================

# step_sequencer

Sequences the four-step uCISC instruction cycle that drives the shared memory port and the immediate loader: instruction fetch, immediate fetch at pc+1, argument read, and result write. Holds each step until memory acknowledges it, skips the write step when the destination is not memory, and handles halt and resume. It also counts retired instructions. Sits between the CPU control path and the memory bus, upstream of the immediate loader's `step` input.

## Interface
- `STEP_FETCH`, 2'd0: step code, instruction read at pc
- `STEP_IMM`, 2'd1: step code, immediate read at pc+1 (immediate loader captures here)
- `STEP_ARGS`, 2'd2: step code, source operand read
- `STEP_WRITE`, 2'd3: step code, destination write
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `mem_ready`  in  1  memory has completed the current read or write this cycle
- `skip_write`  in  1  decoded instruction has no memory write; sampled in `STEP_ARGS`
- `halt_instr`  in  1  decoded instruction is the halt form; sampled in `STEP_ARGS`
- `can_halt`  in  1  captured immediate == 0 (from immediate loader)
- `resume`  in  1  single-cycle pulse, leave halt
- `step`  out  2  current step code
- `mem_read`  out  1  read request for current step
- `mem_write`  out  1  write request for current step
- `pc_advance`  out  1  one-cycle strobe, instruction retired, PC may update
- `halted`  out  1  sequencer stopped
- `retired`  out  16  retired-instruction count

## Operation
- States: RUN (with `step` register) and HALT.
- RUN behaviour:
  - `mem_read` = 1 for steps 0–2.
  - `mem_write` = 1 for step 3.
  - Both are 0 in HALT.
- Step advance: the step completes on a rising edge where `mem_ready`=1. While `mem_ready`=0, `step` holds and the requests stay asserted.
- Step 0 → 1, and step 1 → 2, on completion.
- Step 2 completion:
  - If `halt_instr` && `can_halt`: retire, then go to HALT.
  - Else if `skip_write`: retire, then go to step 0.
  - Else: go to step 3.
  - Halt has priority over `skip_write`.
- Step 3 completion: retire, then go to step 0.
- `halt_instr` with `can_halt`=0 is not a halt. It executes as a normal instruction.
- Retire means:
  - `pc_advance` = 1 for exactly the cycle after the completing edge.
  - `retired` += 1, wrapping 0xFFFF → 0x0000.
- HALT:
  - `step` = `STEP_FETCH`.
  - `halted` = 1.
  - `mem_ready` is ignored.
  - `resume`=1 → next edge RUN at step 0 and `halted` = 0. `resume` is ignored in RUN.
- Reset wins over every other input, including mid-step, a pending retire, and HALT.

## Timing
- Reset values: `step` = 0, `halted` = 0, `pc_advance` = 0, `retired` = 0, `mem_read` = 1, `mem_write` = 0. The sequencer leaves reset in RUN and fetching.
- `step`, `halted`, `pc_advance` and `retired` are registered.
- `mem_read` and `mem_write` are combinational decodes of the state and step registers. They are glitch-free relative to `clock` and have no input-to-output path.
- Minimum instruction length with `mem_ready` tied high:
  - 4 cycles with a write.
  - 3 cycles when `skip_write`=1.
- `pc_advance` never fires on two consecutive cycles.
- `retired` updates on the same edge that sets `pc_advance`.
- `skip_write`, `halt_instr` and `can_halt` only need to be valid on the completing edge of step 2.
- Reset asserted mid-step 3: the write is abandoned, no retire occurs, and the state equals the reset values on the next cycle.

## Structure
- Shared package `ucisc_pkg`: the four step-code constants, used by this block, the immediate loader's capture parameter, and the decode logic.
- Sub-module `retire_counter`: 16-bit wrapping counter with synchronous reset and increment enable. It is instantiated once; all other logic is in `step_sequencer`.

## Test plan
- `mem_ready`=1, `skip_write`=0, 3 instructions → `step` sequence 0,1,2,3 repeating; `pc_advance` pulses at cycles 4, 8, 12; `retired` = 3.
- `mem_ready` low 2 cycles in step 1 → `step` holds at 1 for 3 cycles with `mem_read`=1; no `pc_advance` until step 3 completes.
- `skip_write`=1 → sequence 0,1,2,0; `mem_write` never asserts; retire every 3 cycles.
- `halt_instr`=1, `can_halt`=1 at step 2 → `retired` +1 and `halted`=1; 5 idle cycles show no requests; `resume` pulse → step 0 and `mem_read`=1 the next cycle. Repeat with `can_halt`=0 → proceeds to step 3 and no halt.
- Preload `retired` to 0xFFFF via 65535 retires (or force), then retire once more → `retired` = 0x0000.
- Assert `reset` during step 3, and again while in HALT → next cycle `step`=0, `halted`=0, `retired`=0, `pc_advance`=0, `mem_write`=0.

Source files
------------

// File: rtl/ucisc_pkg.sv
// ucisc_pkg: shared definitions for the uCISC instruction-cycle logic.
// Holds the four step codes used by the sequencer, the immediate loader's
// capture parameter and the decode logic. It also holds the sequencer
// run/halt state type and the retired-count width.
package ucisc_pkg;

  localparam logic [1:0] STEP_FETCH = 2'd0;  // instruction read at pc
  localparam logic [1:0] STEP_IMM   = 2'd1;  // immediate read at pc+1
  localparam logic [1:0] STEP_ARGS  = 2'd2;  // source operand read
  localparam logic [1:0] STEP_WRITE = 2'd3;  // destination write

  localparam int RETIRED_W = 16;

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: bundle between the step sequencer and the CPU
// control path / memory bus.
//   master (sequencer) inputs : mem_ready, skip_write, halt_instr, can_halt, resume
//   master (sequencer) outputs: step, mem_read, mem_write, pc_advance, halted, retired
// The slave modport is the mirror image, for the control path and memory side.
interface step_sequencer_if;
  import ucisc_pkg::*;

  logic                 mem_ready;
  logic                 skip_write;
  logic                 halt_instr;
  logic                 can_halt;
  logic                 resume;
  logic [1:0]           step;
  logic                 mem_read;
  logic                 mem_write;
  logic                 pc_advance;
  logic                 halted;
  logic [RETIRED_W-1:0] retired;

  modport master (
    input  mem_ready, skip_write, halt_instr, can_halt, resume,
    output step, mem_read, mem_write, pc_advance, halted, retired
  );

  modport slave (
    output mem_ready, skip_write, halt_instr, can_halt, resume,
    input  step, mem_read, mem_write, pc_advance, halted, retired
  );

endinterface

// File: rtl/step_sequencer_retire_counter.sv
// retire_counter: wrapping up-counter of retired instructions.
//   clock   : rising-edge clock
//   reset   : synchronous active-high clear
//   inc_i   : increment by one on this edge
//   count_o : current count, wraps from all-ones to zero
module retire_counter #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc_i,
  output logic [DATA_W-1:0] count_o
);

  logic [DATA_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: drives the four-step uCISC instruction cycle
// (fetch, immediate fetch, argument read, result write). Each step is held
// until mem_ready. The write step is skipped for non-memory destinations.
// The sequencer also handles halt/resume and counts retired instructions.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (master) : mem_ready/skip_write/halt_instr/can_halt/resume in;
//                  step/mem_read/mem_write/pc_advance/halted/retired out
module step_sequencer
  import ucisc_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  step_sequencer_if.master bus
);

  seq_state_e state_q, state_d;
  logic [1:0] step_q, step_d;
  logic       pc_adv_q;
  logic       retire_d;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= SEQ_RUN;
      step_q   <= STEP_FETCH;
      pc_adv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      pc_adv_q <= retire_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    retire_d = 1'b0;
    unique case (state_q)
      SEQ_RUN: begin
        if (bus.mem_ready) begin
          unique case (step_q)
            STEP_FETCH: step_d = STEP_IMM;
            STEP_IMM:   step_d = STEP_ARGS;
            STEP_ARGS: begin
              // A halt with a non-zero immediate is an ordinary instruction;
              // a real halt outranks skip_write.
              if (bus.halt_instr && bus.can_halt) begin
                retire_d = 1'b1;
                state_d  = SEQ_HALT;
                step_d   = STEP_FETCH;
              end else if (bus.skip_write) begin
                retire_d = 1'b1;
                step_d   = STEP_FETCH;
              end else begin
                step_d   = STEP_WRITE;
              end
            end
            STEP_WRITE: begin
              retire_d = 1'b1;
              step_d   = STEP_FETCH;
            end
            default: step_d = STEP_FETCH;
          endcase
        end
      end
      SEQ_HALT: begin
        if (bus.resume) begin
          state_d = SEQ_RUN;
          step_d  = STEP_FETCH;
        end
      end
      default: begin
        state_d = SEQ_RUN;
        step_d  = STEP_FETCH;
      end
    endcase
  end

  // Output decode: registers only, so there is no input-to-output path
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (state_q == SEQ_RUN) begin
      bus.mem_read  = (step_q != STEP_WRITE);
      bus.mem_write = (step_q == STEP_WRITE);
    end
  end

  assign bus.step       = step_q;
  assign bus.halted     = (state_q == SEQ_HALT);
  assign bus.pc_advance = pc_adv_q;

  // The count moves on the same edge that raises pc_advance
  retire_counter #(
    .DATA_W (RETIRED_W)
  ) u_retire (
    .clock   (clock),
    .reset   (reset),
    .inc_i   (retire_d),
    .count_o (bus.retired)
  );

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios, then randomized traffic.
// Every cycle is compared against an instruction-level reference model.
module tb_step_sequencer;
  import ucisc_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  step_sequencer_if bus ();

  step_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: which step of the instruction we are in, whether the
  // machine is halted, and how many instructions have been retired.
  int          m_step  = 0;
  bit          m_halt  = 1'b0;
  bit          m_pcadv = 1'b0;
  logic [15:0] m_ret   = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit retire;
    retire = 1'b0;
    if (reset) begin
      m_step = 0; m_halt = 1'b0; m_pcadv = 1'b0; m_ret = 16'h0000;
      return;
    end
    if (m_halt) begin
      if (bus.resume) begin
        m_halt = 1'b0;
        m_step = 0;
      end
    end else if (bus.mem_ready) begin
      if (m_step == 0 || m_step == 1) begin
        m_step = m_step + 1;
      end else if (m_step == 2) begin
        if (bus.halt_instr && bus.can_halt) begin
          retire = 1'b1; m_halt = 1'b1; m_step = 0;
        end else if (bus.skip_write) begin
          retire = 1'b1; m_step = 0;
        end else begin
          m_step = 3;
        end
      end else begin
        retire = 1'b1; m_step = 0;
      end
    end
    m_pcadv = retire;
    if (retire) m_ret = m_ret + 16'd1;
  endtask

  // One clock: update the model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("step",       32'(bus.step),       32'(m_step));
    chk("mem_read",   32'(bus.mem_read),   32'(!m_halt && m_step < 3));
    chk("mem_write",  32'(bus.mem_write),  32'(!m_halt && m_step == 3));
    chk("pc_advance", 32'(bus.pc_advance), 32'(m_pcadv));
    chk("halted",     32'(bus.halted),     32'(m_halt));
    chk("retired",    32'(bus.retired),    32'(m_ret));
  endtask

  task automatic set_in(input bit rdy, input bit skip, input bit hlt, input bit can, input bit res);
    bus.mem_ready  = rdy;
    bus.skip_write = skip;
    bus.halt_instr = hlt;
    bus.can_halt   = can;
    bus.resume     = res;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    chk("rst_step", 32'(bus.step), 32'(STEP_FETCH));
    chk("rst_rd",   32'(bus.mem_read), 32'd1);
    chk("rst_ret",  32'(bus.retired), 32'd0);
    reset = 1'b0;

    // Three instructions with a write step, memory always ready
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i % 4 == 0) chk("pcadv_4cyc", 32'(bus.pc_advance), 32'd1);
    end
    chk("ret_3", 32'(bus.retired), 32'd3);

    // Stall two cycles in the immediate step
    do_reset();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("stall_step", 32'(bus.step), 32'(STEP_IMM));
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_ret", 32'(bus.retired), 32'd1);

    // skip_write: three-cycle instructions
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    chk("skip_ret", 32'(bus.retired), 32'd3);

    // Halt, idle, resume; then a halt form with can_halt=0
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("halt_h",   32'(bus.halted),  32'd1);
    chk("halt_ret", 32'(bus.retired), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    chk("resume_rd", 32'(bus.mem_read), 32'd1);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("nohalt_wr", 32'(bus.mem_write), 32'd1);
    tick();
    chk("nohalt_ret", 32'(bus.retired), 32'd2);

    // Counter wrap: preload all-ones while halted, then retire once
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    force dut.u_retire.cnt_q = 16'hFFFF;
    @(posedge clock);
    #1;
    release dut.u_retire.cnt_q;
    m_ret = 16'hFFFF;
    @(negedge clock);
    bus.resume = 1'b1;
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("wrap", 32'(bus.retired), 32'd0);

    // Reset during the write step, and during halt
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_wr", 32'(bus.mem_write), 32'd1);
    do_reset();
    chk("rst3_wr",  32'(bus.mem_write),  32'd0);
    chk("rst3_pc",  32'(bus.pc_advance), 32'd0);
    chk("rst3_ret", 32'(bus.retired),    32'd0);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    bus.resume = 1'b0;
    tick();
    chk("pre_rst_h", 32'(bus.halted), 32'd1);
    do_reset();
    chk("rsth_h",    32'(bus.halted), 32'd0);
    chk("rsth_step", 32'(bus.step),   32'(STEP_FETCH));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
